// File: rtl/dpp_table.sv
// Dining-philosophers fork arbiter: greedy round-robin grant of fork pairs to hungry philosophers.
// Optional starvation guard enabled by defining DPP_STARVE_GUARD_EN.
module dpp_table #(
    parameter int N_PHILO      = 5,
    parameter int STARVE_LIMIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PHILO-1:0] hungry_in,
    input  logic [N_PHILO-1:0] done_in,
    output logic [N_PHILO-1:0] eat_out,
    output logic [N_PHILO-1:0] eating,
    output logic [N_PHILO-1:0] fork_busy,
    output logic               err
);
    localparam int PW = $clog2(N_PHILO);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_PHILO - 1);
    localparam logic [PW:0]   N_W      = (PW + 1)'(N_PHILO);
    // An out-of-range configuration shows up as a permanently raised err.
    localparam logic PARAMS_OK = (N_PHILO >= 2) && (N_PHILO <= 16) &&
                                 (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 255);

    // Phase encoding keeps "eating" as a direct register bit.
    localparam logic [1:0] PH_THINKING = 2'b00;
    localparam logic [1:0] PH_HUNGRY   = 2'b01;
    localparam logic [1:0] PH_EATING   = 2'b10;

    logic [N_PHILO-1:0] hungry_w;
    logic [N_PHILO-1:0] blocked_w;
    logic [N_PHILO-1:0] grant_w;
    logic [N_PHILO-1:0] bad_req_w;
    logic [N_PHILO-1:0] eating_d;
    logic [N_PHILO-1:0] fork_busy_d;
    logic [N_PHILO-1:0] fork_busy_q;
    logic [N_PHILO-1:0] eat_out_q;
    logic [PW-1:0]      rr_q;
    logic [PW-1:0]      rr_d;
    logic               err_q;
    logic               err_d;
`ifdef DPP_STARVE_GUARD_EN
    logic [N_PHILO-1:0] starving_w;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_PHILO; gi++) begin : g_philo
            localparam int LEFT = (gi + N_PHILO - 1) % N_PHILO;
            logic [1:0] phase_q;
            logic [1:0] phase_d;

            always_comb begin
                phase_d = phase_q;
                case (phase_q)
                    PH_THINKING: if (hungry_in[gi]) phase_d = PH_HUNGRY;
                    PH_HUNGRY:   if (grant_w[gi])   phase_d = PH_EATING;
                    PH_EATING:   if (done_in[gi])   phase_d = PH_THINKING;
                    default:                        phase_d = PH_THINKING;
                endcase
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) phase_q <= PH_THINKING;
                else       phase_q <= phase_d;
            end

            assign hungry_w[gi]    = phase_q[0];
            assign eating[gi]      = phase_q[1];
            assign eating_d[gi]    = phase_d[1];
            // Fork gi is shared by philosopher gi and its left neighbour.
            assign fork_busy_d[gi] = eating_d[gi] | eating_d[LEFT];
            assign bad_req_w[gi]   = (hungry_in[gi] && (phase_q != PH_THINKING)) ||
                                     (done_in[gi]   && (phase_q != PH_EATING));

`ifdef DPP_STARVE_GUARD_EN
            localparam int RIGHT = (gi + 1) % N_PHILO;
            logic [7:0] wait_q;
            logic [7:0] wait_d;

            always_comb begin
                wait_d = 8'd0;
                if ((phase_q == PH_HUNGRY) && !grant_w[gi])
                    wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) wait_q <= 8'd0;
                else       wait_q <= wait_d;
            end

            assign starving_w[gi] = (phase_q == PH_HUNGRY) && (wait_q >= 8'(STARVE_LIMIT));
            assign blocked_w[gi]  = !starving_w[gi] && (starving_w[LEFT] || starving_w[RIGHT]);
`else
            assign blocked_w[gi] = 1'b0;
`endif
        end
    endgenerate

    // Round-robin scan over the forks registered before this edge.
    logic [N_PHILO-1:0] free_w;
    logic [PW:0]        idx_sum;
    logic [PW-1:0]      idx;
    logic [PW-1:0]      nxt;
    always_comb begin
        free_w  = ~fork_busy_q;
        grant_w = '0;
        rr_d    = rr_q;
        idx_sum = '0;
        idx     = '0;
        nxt     = '0;
        for (int k = 0; k < N_PHILO; k++) begin
            idx_sum = {1'b0, rr_q} + (PW + 1)'(k);
            if (idx_sum >= N_W) idx_sum = idx_sum - N_W;
            idx = idx_sum[PW-1:0];
            nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (hungry_w[idx] && !blocked_w[idx] && free_w[idx] && free_w[nxt]) begin
                grant_w[idx] = 1'b1;
                free_w[idx]  = 1'b0;
                free_w[nxt]  = 1'b0;
                rr_d         = nxt;
            end
        end
    end

    assign err_d = err_q | (|bad_req_w) | !PARAMS_OK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fork_busy_q <= '0;
            eat_out_q   <= '0;
            rr_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            fork_busy_q <= fork_busy_d;
            eat_out_q   <= grant_w;
            rr_q        <= rr_d;
            err_q       <= err_d;
        end
    end

    assign eat_out   = eat_out_q;
    assign fork_busy = fork_busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dpp_table.sv
// Bench for dpp_table: directed vector tables plus randomized traffic against a phase-level model.
module tb_dpp_table;
    localparam int N     = 5;
    localparam int LIMIT = 3;
    localparam int TH = 0, HU = 1, EA = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] hungry_in, done_in, eat_out, eating, fork_busy;
    logic         err;

    always #5 clk = ~clk;

    dpp_table #(.N_PHILO(N), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .hungry_in (hungry_in),
        .done_in   (done_in),
        .eat_out   (eat_out),
        .eating    (eating),
        .fork_busy (fork_busy),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: per-philosopher phase, scan pointer, sticky error, wait counts.
    int           ph[N];
    int           wt[N];
    int           rr_m;
    bit           err_m;
    logic [N-1:0] exp_eat;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin ph[i] = TH; wt[i] = 0; end
        rr_m = 0; err_m = 1'b0; exp_eat = '0;
    endfunction

    function automatic logic [N-1:0] model_forks();
        logic [N-1:0] f = '0;
        for (int i = 0; i < N; i++)
            if (ph[i] == EA) begin f[i] = 1'b1; f[(i + 1) % N] = 1'b1; end
        return f;
    endfunction

    function automatic logic [N-1:0] model_eating();
        logic [N-1:0] e = '0;
        for (int i = 0; i < N; i++) e[i] = (ph[i] == EA);
        return e;
    endfunction

    function automatic void model_step(input logic [N-1:0] h, input logic [N-1:0] d);
        logic [N-1:0] used = model_forks();
        logic [N-1:0] g    = '0;
        bit           starv[N];
        int           nph[N];
        int           last = -1;
        for (int i = 0; i < N; i++) starv[i] = 1'b0;
`ifdef DPP_STARVE_GUARD_EN
        for (int i = 0; i < N; i++) starv[i] = (ph[i] == HU) && (wt[i] >= LIMIT);
`endif
        for (int k = 0; k < N; k++) begin
            int  i = (rr_m + k) % N;
            int  j = (i + 1) % N;
            bit  blk = !starv[i] && (starv[(i + N - 1) % N] || starv[j]);
            if (ph[i] == HU && !blk && !used[i] && !used[j]) begin
                g[i] = 1'b1; used[i] = 1'b1; used[j] = 1'b1; last = i;
            end
        end
        if (last >= 0) rr_m = (last + 1) % N;
        for (int i = 0; i < N; i++) begin
            wt[i]  = (ph[i] == HU && !g[i]) ? ((wt[i] < 255) ? wt[i] + 1 : 255) : 0;
            nph[i] = ph[i];
            if (h[i]) begin if (ph[i] == TH) nph[i] = HU; else err_m = 1'b1; end
            if (d[i]) begin if (ph[i] == EA) nph[i] = TH; else err_m = 1'b1; end
            if (g[i]) nph[i] = EA;
        end
        for (int i = 0; i < N; i++) ph[i] = nph[i];
        exp_eat = g;
    endfunction

    task automatic check_invariants(input string tag);
        check({tag, " adjacent eaters"}, eating & {eating[0], eating[N-1:1]}, '0);
        check({tag, " fork_busy vs eating"}, fork_busy, eating | {eating[N-2:0], eating[N-1]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async reset eat_out", eat_out, '0);
        check("async reset eating", eating, '0);
        check("async reset fork_busy", fork_busy, '0);
        check("async reset err", {{(N-1){1'b0}}, err}, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply(input logic [N-1:0] h, input logic [N-1:0] d);
        hungry_in = h;
        done_in   = d;
        @(posedge clk);
        #1;
        hungry_in = '0;
        done_in   = '0;
        model_step(h, d);
    endtask

    typedef struct {
        bit           rst;
        logic [N-1:0] h, d, eat, eat_lv, fb;
        bit           err;
    } vec_t;

    vec_t tbl[$];
    vec_t stv[$];

    function automatic vec_t mk(bit r, logic [N-1:0] h, logic [N-1:0] d, logic [N-1:0] e,
                                logic [N-1:0] lv, logic [N-1:0] fb, bit er);
        vec_t v;
        v.rst = r; v.h = h; v.d = d; v.eat = e; v.eat_lv = lv; v.fb = fb; v.err = er;
        return v;
    endfunction

    task automatic run_row(input string tag, input int n, input vec_t v);
        string nm;
        if (v.rst) do_reset();
        apply(v.h, v.d);
        nm = $sformatf("%s%0d", tag, n);
        $display("%s h=%b d=%b eat_out=%b eating=%b fork_busy=%b err=%b",
                 nm, v.h, v.d, eat_out, eating, fork_busy, err);
        check({nm, " eat_out"}, eat_out, v.eat);
        check({nm, " eating"}, eating, v.eat_lv);
        check({nm, " fork_busy"}, fork_busy, v.fb);
        check({nm, " err"}, {{(N-1){1'b0}}, err}, {{(N-1){1'b0}}, v.err});
        check_invariants(nm);
    endtask

    task automatic run_random(input string tag, input int cycles, input bit illegal);
        logic [N-1:0] h, d;
        string nm;
        for (int c = 0; c < cycles; c++) begin
            h = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                h[i] = (ph[i] == TH) && ($urandom_range(3) == 0);
                d[i] = (ph[i] == EA) && ($urandom_range(2) == 0);
            end
            if (illegal && $urandom_range(40) == 0) begin
                int b = $urandom_range(N - 1);
                d[b] = ~d[b];
            end
            apply(h, d);
            nm = $sformatf("%s%0d", tag, c);
            $display("%s h=%b d=%b eat_out=%b eating=%b fork_busy=%b err=%b",
                     nm, h, d, eat_out, eating, fork_busy, err);
            check({nm, " eat_out"}, eat_out, exp_eat);
            check({nm, " eating"}, eating, model_eating());
            check({nm, " fork_busy"}, fork_busy, model_forks());
            check({nm, " err"}, {{(N-1){1'b0}}, err}, {{(N-1){1'b0}}, err_m});
            check_invariants(nm);
        end
    endtask

    initial begin
        reset = 1'b1; hungry_in = '0; done_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset eat_out", eat_out, '0);
        check("reset eating", eating, '0);
        check("reset fork_busy", fork_busy, '0);
        check("reset err", {{(N-1){1'b0}}, err}, '0);
        @(negedge clk);
        reset = 1'b0;

        //            rst  hungry    done      eat_out   eating    fork_busy err
        tbl.push_back(mk(0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00011, 0));
        tbl.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, 5'b00001, 5'b00011, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00011, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00110, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 1));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1));
        tbl.push_back(mk(1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00101, 5'b00101, 5'b01111, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00101, 5'b01111, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00101, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b01010, 5'b01010, 5'b11110, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b01010, 5'b11110, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b01010, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b10000, 5'b10000, 5'b10001, 0));
        tbl.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00101, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00101, 5'b00101, 5'b01111, 0));
        tbl.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
        for (int n = 0; n < tbl.size(); n++) run_row("row", n, tbl[n]);

        // Philosophers 0 and 2 take turns while philosopher 1 keeps waiting.
        stv.push_back(mk(1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0));
        stv.push_back(mk(0, 5'b00110, 5'b00000, 5'b00001, 5'b00001, 5'b00011, 0));
        stv.push_back(mk(0, 5'b00000, 5'b00001, 5'b00100, 5'b00100, 5'b01100, 0));
        stv.push_back(mk(0, 5'b00001, 5'b00000, 5'b00000, 5'b00100, 5'b01100, 0));
        stv.push_back(mk(0, 5'b00000, 5'b00100, 5'b00001, 5'b00001, 5'b00011, 0));
        stv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00000, 5'b00001, 5'b00011, 0));
`ifdef DPP_STARVE_GUARD_EN
        stv.push_back(mk(0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 0));
        stv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00110, 0));
`else
        stv.push_back(mk(0, 5'b00000, 5'b00001, 5'b00100, 5'b00100, 5'b01100, 0));
        stv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b01100, 0));
`endif
        for (int n = 0; n < stv.size(); n++) run_row("starve", n, stv[n]);

        do_reset();
        run_random("rnd_legal", 300, 1'b0);
        do_reset();
        run_random("rnd_mixed", 300, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
